imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64, instruction-memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 6, word-address width; SHALL equal clog2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  byte-stream source has a valid byte.
REQ-006 in_data  input  8  byte-stream payload.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 imem_wdata  output  32  instruction-memory write data.
REQ-011 cpu_rst  output  1  holds the processor core in reset while loading.
REQ-012 load_done  output  1  image fully written.
REQ-013 load_err  output  1  image rejected.

Function
REQ-014 Byte is accepted only on a cycle where in_valid=1 and in_ready=1; all other in_data values are ignored.
REQ-015 Stream format: 4-byte word count N, then N 4-byte instruction words; all fields little-endian, first byte to bits 7:0.
REQ-016 States: S_LEN (collect N), S_DATA (collect word), S_WRITE (issue write), S_DONE, S_ERR.
REQ-017 in_ready=1 in S_LEN and S_DATA; 0 in S_WRITE, S_DONE and S_ERR.
REQ-018 2-bit byte counter increments per accepted byte, wraps 3->0, and is 0 on entry to S_LEN and S_DATA.
REQ-019 On the 4th accepted length byte: N=0 -> S_DONE; N>DEPTH -> S_ERR; otherwise -> S_DATA with word index 0.
REQ-020 On the 4th accepted data byte -> S_WRITE; imem_we=1 for exactly that one cycle, imem_addr=word index, imem_wdata=assembled word.
REQ-021 Write latency: imem_we SHALL be asserted in the cycle immediately after the 4th byte of a word is accepted.
REQ-022 Leaving S_WRITE: if word index = N-1 -> S_DONE; otherwise the index increments and the next state is S_DATA.
REQ-023 imem_we=0 in every state other than S_WRITE; imem_addr and imem_wdata hold their last values when imem_we=0.
REQ-024 cpu_rst=1 in every state except S_DONE; load_done=1 only in S_DONE; load_err=1 only in S_ERR.
REQ-025 S_DONE and S_ERR are terminal until rst; bytes offered in these states are not consumed.
REQ-026 N is compared as a full 32-bit unsigned value; values above DEPTH, including 0xFFFFFFFF, go to S_ERR without any write.

Reset
REQ-027 While rst=1 at a clock edge: state S_LEN, byte counter 0, word index 0, N 0, imem_we 0, imem_addr 0, imem_wdata 0, in_ready 1 after release, cpu_rst 1, load_done 0, load_err 0.
REQ-028 Reset mid-load abandons the partial word with no write; memory contents already written are not cleared.

Structure
REQ-029 Shared package holds the state enum, BYTES_PER_WORD=4, and the default DEPTH.
REQ-030 One sub-module, byte_assembler, implements the byte counter and the 32-bit little-endian shift/assemble register, with a word_ready pulse; it is reused for N and the data words.

Verification
REQ-031 Stream 02 00 00 00, 13 00 00 00, 93 00 10 00 -> two writes (addr 0, 0x00000013) and (addr 1, 0x00100093); then load_done=1 and cpu_rst=0.
REQ-032 Stream 00 00 00 00 -> no imem_we; load_done=1 one cycle after the 4th byte.
REQ-033 Stream 41 00 00 00 with DEPTH=64 -> load_err=1, cpu_rst stays 1, no imem_we, in_ready=0.
REQ-034 Source toggles in_valid every other cycle with N=1, word AA BB CC DD -> single write 0xDDCCBBAA at addr 0; in_ready=0 during S_WRITE.
REQ-035 rst pulsed after 2 data bytes of word 1 of N=3 -> no write for the partial word; the loader restarts in S_LEN and a fresh stream loads correctly.
REQ-036 DEPTH=64 with N=64 -> last write at addr 63; load_done asserted with no address wrap.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Includes the state encoding, word geometry and the length check.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_DEPTH  = 64;

  typedef logic [2:0] state_t;

  localparam state_t S_LEN   = 3'd0;
  localparam state_t S_DATA  = 3'd1;
  localparam state_t S_WRITE = 3'd2;
  localparam state_t S_DONE  = 3'd3;
  localparam state_t S_ERR   = 3'd4;

  // Full 32-bit unsigned compare so that huge counts such as 0xFFFFFFFF are rejected.
  function automatic logic len_too_big(input logic [31:0] n, input int depth);
    return n > 32'(depth);
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler with a wrapping byte counter.
// word_ready is combinational so the completed word is usable on the accepting edge.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_shift;
  logic             w_last;

  assign w_last       = (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign o_word_ready = i_vld && w_last;
  assign o_word       = {i_byte, r_shift};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_vld) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Earlier bytes drift toward bit 0, so the first byte lands in bits 7:0.
  always_ff @(posedge clk) begin
    if (i_vld) begin
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes it into
// instruction memory one word at a time, and releases the core when complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_len;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_acc;
  logic [31:0]       w_word;
  logic              w_word_ready;
  logic              w_last_word;

  assign in_ready    = (r_state == S_LEN) || (r_state == S_DATA);
  assign w_acc       = in_valid && in_ready;
  assign w_last_word = (32'(r_idx) == (r_len - 32'd1));

  byte_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_vld        (w_acc),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LEN;
      r_idx   <= '0;
      r_len   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_LEN: begin
          if (w_word_ready) begin
            if (w_word == 32'd0) begin
              r_state <= S_DONE;
            end else if (len_too_big(w_word, DEPTH)) begin
              r_state <= S_ERR;
            end else begin
              r_len   <= w_word;
              r_idx   <= '0;
              r_state <= S_DATA;
            end
          end
        end
        // Write strobe is registered here so it rises on the edge that takes the 4th byte.
        S_DATA: begin
          if (w_word_ready) begin
            r_we    <= 1'b1;
            r_addr  <= r_idx;
            r_wdata <= w_word;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_last_word) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + ADDR_W'(1);
            r_state <= S_DATA;
          end
        end
        S_DONE:  r_state <= S_DONE;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_ERR;
      endcase
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_rst    = (r_state != S_DONE);
  assign load_done  = (r_state == S_DONE);
  assign load_err   = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized load streams checked against a stream-level model
// of the expected memory writes and final loader status.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  strm[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Capture every write; it must follow the accepting edge directly and block input.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(32'(imem_addr));
      wd.push_back(imem_wdata);
      chk("we_latency", 32'(cyc), 32'(acc_cyc));
      chk("ready_in_write", 32'(in_ready), 32'd0);
    end
  end

  task automatic push_word(input logic [31:0] w);
    strm.push_back(w[7:0]);
    strm.push_back(w[15:8]);
    strm.push_back(w[23:16]);
    strm.push_back(w[31:24]);
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    int t;
    in_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Model: header decides the outcome, then every 4 bytes form one word at the next address.
  task automatic do_load(input string tag, input int gap, input bit toggle);
    logic [31:0] n;
    logic [31:0] w;
    bit er;
    int nw;
    int sz;
    n  = {strm[3], strm[2], strm[1], strm[0]};
    er = (n > 32'(DEPTH));
    nw = (n == 0 || er) ? 0 : int'(n);
    wa.delete();
    wd.delete();
    foreach (strm[i]) send_byte(strm[i], toggle ? 1 : int'($urandom_range(0, gap)));
    if (nw == 0)
      chk($sformatf("%s_imm", tag), 32'(er ? load_err : load_done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("%s_nwr", tag), 32'(wa.size()), 32'(nw));
    for (int i = 0; i < nw && i < wa.size(); i++) begin
      w = {strm[4*i+7], strm[4*i+6], strm[4*i+5], strm[4*i+4]};
      chk($sformatf("%s_addr%0d", tag, i), wa[i], 32'(i));
      chk($sformatf("%s_data%0d", tag, i), wd[i], w);
    end
    if (nw > 0) begin
      chk($sformatf("%s_hold_addr", tag), 32'(imem_addr), 32'(nw - 1));
      chk($sformatf("%s_hold_data", tag), imem_wdata,
          {strm[4*nw+3], strm[4*nw+2], strm[4*nw+1], strm[4*nw]});
    end
    chk($sformatf("%s_done", tag), 32'(load_done), 32'(!er));
    chk($sformatf("%s_err", tag), 32'(load_err), 32'(er));
    chk($sformatf("%s_cpu_rst", tag), 32'(cpu_rst), 32'(er));
    chk($sformatf("%s_ready", tag), 32'(in_ready), 32'd0);
    sz = wa.size();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk($sformatf("%s_term_nwr", tag), 32'(wa.size()), 32'(sz));
    chk($sformatf("%s_term_state", tag), {30'd0, load_done, load_err}, {30'd0, !er, er});
  endtask

  initial begin
    logic [31:0] n;
    do_reset("rst0");

    strm.delete();
    push_word(32'd2); push_word(32'h00000013); push_word(32'h00100093);
    do_load("two_words", 0, 1'b0);

    do_reset("rst1");
    strm.delete();
    push_word(32'd0);
    do_load("zero_len", 2, 1'b0);

    do_reset("rst2");
    strm.delete();
    push_word(32'h41);
    do_load("too_long", 0, 1'b0);

    do_reset("rst3");
    strm.delete();
    push_word(32'd1); push_word(32'hDDCCBBAA);
    do_load("toggle", 0, 1'b1);

    // Abandon a partial second word with a reset, then reload cleanly.
    do_reset("rst4");
    wa.delete();
    wd.delete();
    strm.delete();
    push_word(32'd3); push_word(32'hCAFEF00D);
    strm.push_back(8'h11); strm.push_back(8'h22);
    foreach (strm[i]) send_byte(strm[i], 0);
    repeat (2) @(posedge clk);
    #1;
    chk("partial_pre_nwr", 32'(wa.size()), 32'd1);
    do_reset("mid_rst");
    repeat (3) @(posedge clk);
    #1;
    chk("partial_post_nwr", 32'(wa.size()), 32'd1);
    strm.delete();
    push_word(32'd2); push_word(32'h12345678); push_word(32'h9ABCDEF0);
    do_load("reload", 1, 1'b0);

    do_reset("rst5");
    strm.delete();
    push_word(32'd64);
    for (int k = 0; k < 64; k++) push_word($urandom);
    do_load("full_depth", 0, 1'b0);

    do_reset("rst6");
    strm.delete();
    push_word(32'hFFFFFFFF);
    do_load("max_len", 1, 1'b0);

    for (int r = 0; r < 5; r++) begin
      do_reset($sformatf("rrst%0d", r));
      strm.delete();
      n = (r == 4) ? 32'd65 : 32'($urandom_range(1, DEPTH));
      push_word(n);
      if (n <= 32'(DEPTH))
        for (int k = 0; k < int'(n); k++) push_word($urandom);
      do_load($sformatf("rand%0d", r), 3, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
